// File: rtl/pipo_load_arbiter_4ch.sv
// pipo_load_arbiter_4ch: round-robin owner of one shared PIPO register.
// Each win loads the word for one cycle, then holds it for the owner for up to HOLD_CYCLES.
module pipo_load_arbiter_4ch #(
  parameter int DATA_WIDTH  = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                    Clk_In,
  input  logic                    Reset_In,
  input  logic [3:0]              Req_In,
  input  logic [4*DATA_WIDTH-1:0] Req_Data_In,
  input  logic                    Release_In,
  output logic [3:0]              Grant_Out,
  output logic [1:0]              Owner_Id_Out,
  output logic                    Owner_Valid_Out,
  output logic                    Pipo_Enable_Out,
  output logic                    Pipo_Load_Out,
  output logic [DATA_WIDTH-1:0]   Pipo_Data_Out
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_e;
  state_e                state_q, state_d;
  logic [1:0]            ptr_q, ptr_d, owner_q, owner_d, win;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            grant_q, grant_d;
  logic                  valid_q, valid_d, en_q, en_d, load_q, load_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  // Scan from the farthest offset down so the nearest set bit after ptr wins.
  always_comb begin
    win = ptr_q;
    for (int k = 3; k >= 0; k--)
      if (Req_In[ptr_q + 2'(k)]) win = ptr_q + 2'(k);
  end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    grant_d = '0;
    valid_d = 1'b0;
    en_d    = 1'b0;
    load_d  = 1'b0;
    case (state_q)
      IDLE: if (|Req_In) begin
        state_d = LOAD;
        grant_d = 4'b0001 << win;
        owner_d = win;
        data_d  = Req_Data_In[win*DATA_WIDTH +: DATA_WIDTH];
        load_d  = 1'b1;
        en_d    = 1'b1;
      end
      LOAD: begin
        state_d = HOLD;
        valid_d = 1'b1;
        en_d    = 1'b1;
        cnt_d   = CW'(1);
      end
      HOLD: if (Release_In || cnt_q == CW'(HOLD_CYCLES)) begin
        state_d = IDLE;
        ptr_d   = owner_q + 2'd1;
      end else begin
        valid_d = 1'b1;
        en_d    = 1'b1;
        cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk_In or negedge Reset_In)
    if (!Reset_In) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      en_q    <= 1'b0;
      load_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      en_q    <= en_d;
      load_q  <= load_d;
      data_q  <= data_d;
    end
  assign Grant_Out       = grant_q;
  assign Owner_Id_Out    = owner_q;
  assign Owner_Valid_Out = valid_q;
  assign Pipo_Enable_Out = en_q;
  assign Pipo_Load_Out   = load_q;
  assign Pipo_Data_Out   = data_q;
endmodule

// File: tb/tb_pipo_load_arbiter_4ch.sv
// tb_pipo_load_arbiter_4ch: randomized bench with a transaction-timeline reference model.
// Instance 0 uses HOLD_CYCLES=4, instance 1 uses HOLD_CYCLES=1.
module tb_pipo_load_arbiter_4ch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req   [2];
  logic [31:0] rdata [2];
  logic        rel   [2];
  logic [3:0]  gnt   [2];
  logic [1:0]  oid   [2];
  logic        ov    [2];
  logic        pen   [2];
  logic        pld   [2];
  logic [7:0]  pdat  [2];
  logic [16:0] act   [2];
  int checks = 0;
  int errors = 0;
  bit          m_busy [2];
  int          m_age  [2];
  int          m_ptr  [2];
  int          m_own  [2];
  logic [7:0]  m_dat  [2];

  always #5 clk = ~clk;

  pipo_load_arbiter_4ch #(.DATA_WIDTH(8), .HOLD_CYCLES(4)) dut0 (
    .Clk_In(clk), .Reset_In(rst_n), .Req_In(req[0]), .Req_Data_In(rdata[0]),
    .Release_In(rel[0]), .Grant_Out(gnt[0]), .Owner_Id_Out(oid[0]),
    .Owner_Valid_Out(ov[0]), .Pipo_Enable_Out(pen[0]), .Pipo_Load_Out(pld[0]),
    .Pipo_Data_Out(pdat[0]));

  pipo_load_arbiter_4ch #(.DATA_WIDTH(8), .HOLD_CYCLES(1)) dut1 (
    .Clk_In(clk), .Reset_In(rst_n), .Req_In(req[1]), .Req_Data_In(rdata[1]),
    .Release_In(rel[1]), .Grant_Out(gnt[1]), .Owner_Id_Out(oid[1]),
    .Owner_Valid_Out(ov[1]), .Pipo_Enable_Out(pen[1]), .Pipo_Load_Out(pld[1]),
    .Pipo_Data_Out(pdat[1]));

  assign act[0] = {gnt[0], oid[0], ov[0], pen[0], pld[0], pdat[0]};
  assign act[1] = {gnt[1], oid[1], ov[1], pen[1], pld[1], pdat[1]};

  function automatic int hold_of(input int n);
    return (n == 0) ? 4 : 1;
  endfunction

  // Model: a transaction is age 0 (load cycle) then ages 1..H (hold), cut short by release.
  function automatic logic [16:0] exp_out(input int n);
    logic ld = m_busy[n] && m_age[n] == 0;
    logic [3:0] g = ld ? 4'(1 << m_own[n]) : 4'b0;
    return {g, 2'(m_own[n]), m_busy[n] && m_age[n] >= 1, m_busy[n], ld, m_dat[n]};
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_busy[n] = 0; m_age[n] = 0; m_ptr[n] = 0; m_own[n] = 0; m_dat[n] = '0;
    end
  endtask

  task automatic model_edge(input int n);
    if (!m_busy[n]) begin
      if (req[n] != 4'b0) begin
        for (int i = 0; i < 4; i++) begin
          int c = (m_ptr[n] + i) % 4;
          if (req[n][c]) begin m_own[n] = c; break; end
        end
        m_dat[n] = rdata[n][m_own[n]*8 +: 8];
        m_busy[n] = 1; m_age[n] = 0;
      end
    end else if (m_age[n] >= 1 && (rel[n] || m_age[n] == hold_of(n))) begin
      m_busy[n] = 0;
      m_ptr[n] = (m_own[n] + 1) % 4;
    end else m_age[n]++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin model_edge(0); model_edge(1); end
    @(negedge clk);
  endtask

  task automatic test_reset_state();
    for (int n = 0; n < 2; n++) begin
      checks++;
      if (act[n] !== 17'h0 || act[n] !== exp_out(n)) begin
        errors++; $display("FAIL reset_state inst%0d got %h exp %h", n, act[n], 17'h0);
      end
    end
  endtask

  task automatic test_round_robin();
    int gid[$];
    logic [7:0] gd[$];
    int gt[$];
    req[0] = 4'b1111; rdata[0] = 32'h44332211;
    for (int t = 0; t < 32; t++) begin
      tick();
      checks++;
      if (act[0] !== exp_out(0)) begin
        errors++; $display("FAIL rr_cycle t%0d got %h exp %h", t, act[0], exp_out(0));
      end
      if (gnt[0] != 4'b0) begin
        gid.push_back(int'(oid[0])); gd.push_back(pdat[0]); gt.push_back(t);
        if (gid.size() == 5) req[0] = 4'b0;
      end
    end
    checks++;
    if (gid.size() != 5) begin
      errors++; $display("FAIL rr_count got %0d exp 5", gid.size());
    end else
      for (int g = 0; g < 5; g++) begin
        logic [7:0] ed = 8'h11 * 8'((g % 4) + 1);
        checks++;
        if (gid[g] != g % 4 || gd[g] !== ed || gt[g] != 6 * g) begin
          errors++;
          $display("FAIL rr_grant%0d got id%0d data %h t%0d exp id%0d data %h t%0d",
                   g, gid[g], gd[g], gt[g], g % 4, ed, 6 * g);
        end
      end
  endtask

  task automatic test_single();
    int vc = 0;
    rdata[0] = $urandom(); rdata[0][23:16] = 8'h3C; req[0] = 4'b0100;
    tick();
    checks++;
    if (gnt[0] !== 4'b0100 || pld[0] !== 1'b1 || pdat[0] !== 8'h3C || act[0] !== exp_out(0)) begin
      errors++; $display("FAIL single_grant got %h exp %h", act[0], exp_out(0));
    end
    req[0] = 4'b0; rdata[0] = $urandom();
    for (int t = 1; t < 8; t++) begin
      tick();
      checks++;
      if (act[0] !== exp_out(0)) begin
        errors++; $display("FAIL single_cycle t%0d got %h exp %h", t, act[0], exp_out(0));
      end
      vc += int'(ov[0]);
    end
    checks++;
    if (vc != 4 || pen[0] !== 1'b0) begin
      errors++; $display("FAIL single_valid_len got %0d en %b exp 4 en 0", vc, pen[0]);
    end
  endtask

  task automatic test_reset();
    rdata[0] = $urandom(); rdata[0][23:16] = 8'hA5; req[0] = 4'b0100;
    tick(); req[0] = 4'b0; tick(); tick();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (act[0] !== 17'h0 || act[0] !== exp_out(0)) begin
      errors++; $display("FAIL reset_mid_hold got %h exp %h", act[0], 17'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req[0] = 4'b1001; rdata[0] = $urandom();
    tick();
    checks++;
    if (gnt[0] !== 4'b0001 || act[0] !== exp_out(0)) begin
      errors++; $display("FAIL reset_ptr got %h exp %h", act[0], exp_out(0));
    end
    req[0] = 4'b0;
    for (int t = 0; t < 6; t++) begin
      tick();
      checks++;
      if (act[0] !== exp_out(0)) begin
        errors++; $display("FAIL reset_drain t%0d got %h exp %h", t, act[0], exp_out(0));
      end
    end
  endtask

  task automatic test_release();
    int rcs[2] = '{2, 0};
    int evs[2] = '{2, 4};
    for (int r = 0; r < 2; r++) begin
      int vc = 0;
      req[0] = 4'b0010; rdata[0] = $urandom();
      tick();
      req[0] = 4'b0; rel[0] = (rcs[r] == 0);
      for (int c = 1; c <= 8; c++) begin
        tick();
        checks++;
        if (act[0] !== exp_out(0)) begin
          errors++; $display("FAIL release%0d_c%0d got %h exp %h", r, c, act[0], exp_out(0));
        end
        vc += int'(ov[0]);
        rel[0] = (c == rcs[r]);
      end
      rel[0] = 1'b0;
      checks++;
      if (vc != evs[r]) begin
        errors++; $display("FAIL release%0d_len got %0d exp %0d", r, vc, evs[r]);
      end
    end
  endtask

  task automatic test_fairness();
    int t = 0;
    req[0] = 4'b0010; rdata[0] = $urandom();
    tick();
    req[0] = 4'b1011;
    tick();
    req[0] = 4'b1010;
    do begin
      tick(); t++;
      checks++;
      if (act[0] !== exp_out(0)) begin
        errors++; $display("FAIL fair_cycle t%0d got %h exp %h", t, act[0], exp_out(0));
      end
    end while (gnt[0] == 4'b0 && t < 12);
    checks++;
    if (gnt[0] !== 4'b1000) begin
      errors++; $display("FAIL fair_winner got %b exp 1000", gnt[0]);
    end
    req[0] = 4'b0;
    repeat (6) tick();
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      for (int n = 0; n < 2; n++) begin
        req[n] = ($urandom_range(0, 2) == 0) ? 4'b0 : 4'($urandom());
        rdata[n] = $urandom();
        rel[n] = ($urandom_range(0, 4) == 0);
      end
      tick();
      for (int n = 0; n < 2; n++) begin
        checks++;
        if (act[n] !== exp_out(n)) begin
          errors++; $display("FAIL random_inst%0d t%0d got %h exp %h", n, t, act[n], exp_out(n));
        end
      end
    end
    req[0] = 4'b0; req[1] = 4'b0; rel[0] = 1'b0; rel[1] = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_back_to_back();
    int gt[$];
    logic [7:0] sent;
    req[1] = 4'b0001; rdata[1] = $urandom(); sent = rdata[1][7:0];
    for (int t = 0; t < 12; t++) begin
      tick();
      checks++;
      if (act[1] !== exp_out(1)) begin
        errors++; $display("FAIL b2b_cycle t%0d got %h exp %h", t, act[1], exp_out(1));
      end
      if (gnt[1] != 4'b0) begin
        checks++;
        if (pdat[1] !== sent) begin
          errors++; $display("FAIL b2b_data t%0d got %h exp %h", t, pdat[1], sent);
        end
        gt.push_back(t);
        rdata[1] = $urandom(); sent = rdata[1][7:0];
      end
    end
    req[1] = 4'b0;
    checks++;
    if (gt.size() != 4) begin
      errors++; $display("FAIL b2b_count got %0d exp 4", gt.size());
    end else
      for (int g = 1; g < 4; g++) begin
        checks++;
        if (gt[g] - gt[g-1] != 3) begin
          errors++; $display("FAIL b2b_period%0d got %0d exp 3", g, gt[g] - gt[g-1]);
        end
      end
    repeat (4) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    for (int n = 0; n < 2; n++) begin req[n] = 4'b0; rdata[n] = '0; rel[n] = 1'b0; end
    model_reset();
    repeat (2) @(negedge clk);
    test_reset_state();
    rst_n = 1'b1;
    test_round_robin();
    test_single();
    test_reset();
    test_release();
    test_fairness();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
